adc_spi_master: RTL and testbench
=================================

# adc_spi_master

Drives the external 16-channel, 10-bit SPI ADC on behalf of the ADC auto-update sequencer. It accepts a one-cycle `adc_go` with a 4-bit channel number, runs one fixed 16-bit SPI frame, and returns the 10-bit conversion result with a one-cycle `adc_valid` strobe. It is the slave side of the `adc_go`/`adc_chan`/`adc_in`/`adc_valid` handshake and the master side of the ADC SPI pins.

## Interface
- `FRAME_BITS`, 16: SCLK periods per frame.
- `RESULT_BITS`, 10: width of the conversion result.
- `QUIET_CYCLES`, 2: minimum `clk3p2M` cycles with CS high between frames.
- `clk3p2M` input 1: 3.2 MHz system clock. Everything is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `adc_go` input 1: conversion request, one-cycle pulse, sampled only in IDLE.
- `adc_chan` input 4: channel number, captured on the edge that accepts `adc_go`.
- `adc_in` output 10: last conversion result.
- `adc_valid` output 1: one-cycle strobe, `adc_in` is new.
- `adc_busy` output 1: high from go acceptance until return to IDLE.
- `adc_cs_n` output 1: ADC chip select, active low.
- `adc_sclk` output 1: SPI clock, idles low (mode 0), runs at `clk3p2M`/2.
- `adc_mosi` output 1: command bit to the ADC.
- `adc_miso` input 1: data bit from the ADC, already synchronous to the board clock domain.

## Operation
- **MOSI command word:** bit15 = 1 (start), bit14 = 1 (single-ended), bits13:10 = channel, bits9:0 = 0. Sent MSB first.
- **MISO data:** the result arrives MSB first during SCLK periods 7..16 (the last 10 periods).
- **States:** IDLE → SETUP → SHIFT → HOLD → DONE → QUIET → IDLE.
- **IDLE:** `adc_cs_n` = 1, `adc_sclk` = 0, `adc_mosi` = 0. If `adc_go` = 1, capture `adc_chan`, load the command shift register and go to SETUP.
- **SETUP (1 cycle):** `adc_cs_n` = 0 and `adc_mosi` = bit15.
- **SHIFT (2×FRAME_BITS = 32 cycles):** a 5-bit phase counter runs 0..31.
  - Even phase: drive `adc_sclk` high and shift `adc_miso` into the 16-bit receive register.
  - Odd phase: drive `adc_sclk` low and present the next MOSI bit.
  - After phase 31, `adc_sclk` is low.
- **HOLD (1 cycle):** `adc_cs_n` = 0 and `adc_sclk` = 0. Load `adc_in` from receive register bits [9:0].
- **DONE (1 cycle):** `adc_valid` = 1 and `adc_cs_n` = 1.
- **QUIET:** hold for QUIET_CYCLES cycles, then go to IDLE.
- **`adc_go` outside IDLE:** ignored. There is no queueing and no error flag.
- **`adc_chan` after acceptance:** changes have no effect on the frame in progress.
- **`adc_in`:** changes only at HOLD and holds its value otherwise, including across ignored requests.
- **Reset (asynchronous, any state including mid-frame):**
  - State returns to IDLE and the counters clear.
  - `adc_cs_n` = 1, `adc_sclk` = 0, `adc_mosi` = 0, `adc_valid` = 0, `adc_busy` = 0, `adc_in` = 10'd0.
  - A frame aborted by reset produces no `adc_valid`.
- **Unused state encodings:** recover to IDLE with outputs at their reset values.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Edge 0 is the edge that samples `adc_go` = 1 in IDLE.
  - `adc_busy` and `adc_cs_n` low are visible after edge 0.
  - The first SCLK rising edge comes after edge 1.
  - `adc_in` updates after edge 34.
  - `adc_valid` is high for the single cycle after edge 35.
- **Quiet time:** CS-high time between frames is at least QUIET_CYCLES+1 = 3 cycles (DONE plus QUIET).
- **Earliest next request:** the next `adc_go` is accepted at edge 38. A back-to-back frame therefore takes 38 cycles (≈11.9 µs).
- **Compatibility with the sequencer:** it issues `adc_go` 2 cycles after `adc_valid`, i.e. at edge 37, while the block is still in QUIET. That request is ignored and recovered only by the sequencer's timeout. Required: the sequencer changes its post-valid delay to at least 3 cycles, or QUIET_CYCLES is reduced to 1.
- **SPI timing:**
  - SCLK high and low times are each 312.5 ns.
  - MOSI changes only while SCLK is low, half a period before the rising edge.
  - MISO is sampled on the same edge that raises SCLK. This captures the bit the ADC shifted out after the previous falling edge.

## Structure
- **Shared header `adc_spi_defs.vh`:** state encodings (3-bit), `FRAME_BITS`, `RESULT_BITS`, command bit positions (start = 15, single-ended = 14, channel = 13:10).
- **Single module with no sub-module.** The shift, phase-counter and FSM logic fits in about 150–200 lines. The ADC behavioural model (`adc_spi_model`) lives in the testbench only.

## Test plan
- **Single conversion:** reset, then `adc_go` with `adc_chan` = 5; model returns 10'h2A5. Required: MOSI frame captured by the model = 16'hD400, `adc_in` = 10'h2A5, `adc_valid` a single pulse after edge 35, 16 SCLK rising edges while CS is low.
- **Full sweep:** channels 0..15 with the model returning {channel, 6'h3F}. Required: each `adc_in` matches; channel 15 command = 16'hFC00.
- **Request while busy:** `adc_go` at edges 10 and 36 with a different channel. Required: ignored, exactly one frame and one `adc_valid`, `adc_in` unchanged by the second request.
- **Reset mid-frame:** assert `rst_n` low at edge 20. Required: immediately `adc_cs_n` = 1, `adc_sclk` = 0, `adc_in` = 0, no `adc_valid`; after release, a new go completes normally.
- **Quiet-time check:** `adc_go` held high continuously. Required: frames every 38 cycles, CS high for at least 3 cycles between frames, MOSI stable while SCLK is high.
- **Sequencer integration:** connect to the auto-update sequencer with QUIET_CYCLES = 1. Required: channels 0..15 update cyclically with no sequencer timeout.

Source files
------------

// File: rtl/adc_spi_master_pkg.sv
// Shared constants, state encoding and command-word builder for the ADC SPI master.
package adc_spi_master_pkg;

    localparam int FRAME_BITS           = 16;
    localparam int RESULT_BITS          = 10;
    localparam int DEFAULT_QUIET_CYCLES = 2;

    localparam int CMD_START_BIT = 15;
    localparam int CMD_SE_BIT    = 14;
    localparam int CMD_CHAN_HI   = 13;
    localparam int CMD_CHAN_LO   = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_QUIET = 3'd5
    } adc_state_t;

    function automatic logic [FRAME_BITS-1:0] buildCommand(input logic [3:0] chan);
        logic [FRAME_BITS-1:0] cmd;
        cmd                           = '0;
        cmd[CMD_START_BIT]            = 1'b1;
        cmd[CMD_SE_BIT]               = 1'b1;
        cmd[CMD_CHAN_HI:CMD_CHAN_LO]  = chan;
        return cmd;
    endfunction

endpackage

// File: rtl/adc_spi_master.sv
// SPI master for the 16-channel 10-bit ADC: one go pulse runs one 16-bit frame
// and returns the conversion result with a single-cycle valid strobe.
module adc_spi_master
    import adc_spi_master_pkg::*;
#(
    parameter int QUIET_CYCLES = DEFAULT_QUIET_CYCLES
) (
    input  logic                   clk3p2M,
    input  logic                   rst_n,
    input  logic                   adc_go,
    input  logic [3:0]             adc_chan,
    output logic [RESULT_BITS-1:0] adc_in,
    output logic                   adc_valid,
    output logic                   adc_busy,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    output logic                   adc_mosi,
    input  logic                   adc_miso
);

    localparam logic [4:0] PHASE_LAST = 5'(2 * FRAME_BITS - 1);
    localparam logic [3:0] QUIET_LAST = 4'(QUIET_CYCLES - 1);

    adc_state_t             r_state;
    logic [4:0]             r_phase;
    logic [3:0]             r_quietCnt;
    logic [FRAME_BITS-1:0]  r_txShift;
    logic [RESULT_BITS-1:0] r_rxShift;
    logic [RESULT_BITS-1:0] r_adcIn;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_csN;
    logic                   r_sclk;
    logic                   r_mosi;
    logic [FRAME_BITS-1:0]  w_cmd;

    assign w_cmd = buildCommand(adc_chan);

    // Outputs are registered one edge ahead of the state they describe, so SCLK
    // rises on the edge that leaves SETUP and MISO is captured on that same edge.
    always_ff @(posedge clk3p2M or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_quietCnt <= '0;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_adcIn    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_csN      <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (adc_go) begin
                        r_txShift <= w_cmd;
                        r_mosi    <= w_cmd[CMD_START_BIT];
                        r_csN     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_phase   <= '0;
                    r_sclk    <= 1'b1;
                    r_rxShift <= {r_rxShift[RESULT_BITS-2:0], adc_miso};
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_phase == PHASE_LAST) begin
                        r_sclk  <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_phase <= r_phase + 5'd1;
                        // The current phase being odd means the next one raises SCLK.
                        if (r_phase[0]) begin
                            r_sclk    <= 1'b1;
                            r_rxShift <= {r_rxShift[RESULT_BITS-2:0], adc_miso};
                        end else begin
                            r_sclk    <= 1'b0;
                            r_txShift <= r_txShift << 1;
                            r_mosi    <= r_txShift[FRAME_BITS-2];
                        end
                    end
                end
                ST_HOLD: begin
                    r_adcIn <= r_rxShift;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_valid    <= 1'b1;
                    r_csN      <= 1'b1;
                    r_quietCnt <= '0;
                    r_state    <= ST_QUIET;
                end
                ST_QUIET: begin
                    if (r_quietCnt == QUIET_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_quietCnt <= r_quietCnt + 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_phase    <= '0;
                    r_quietCnt <= '0;
                    r_txShift  <= '0;
                    r_rxShift  <= '0;
                    r_adcIn    <= '0;
                    r_busy     <= 1'b0;
                    r_csN      <= 1'b1;
                    r_sclk     <= 1'b0;
                    r_mosi     <= 1'b0;
                end
            endcase
        end
    end

    assign adc_in    = r_adcIn;
    assign adc_valid = r_valid;
    assign adc_busy  = r_busy;
    assign adc_cs_n  = r_csN;
    assign adc_sclk  = r_sclk;
    assign adc_mosi  = r_mosi;

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench for adc_spi_master with a behavioural mode-0 ADC model.
module tb_adc_spi_master;

    logic       clk3p2M  = 1'b0;
    logic       rst_n    = 1'b1;
    logic       adc_go   = 1'b0;
    logic [3:0] adc_chan = 4'd0;
    logic       adc_miso = 1'b0;
    logic [9:0] adc_in;
    logic       adc_valid;
    logic       adc_busy;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic       adc_mosi;

    int total = 0;
    int bad   = 0;

    adc_spi_master dut (
        .clk3p2M   (clk3p2M),
        .rst_n     (rst_n),
        .adc_go    (adc_go),
        .adc_chan  (adc_chan),
        .adc_in    (adc_in),
        .adc_valid (adc_valid),
        .adc_busy  (adc_busy),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .adc_mosi  (adc_mosi),
        .adc_miso  (adc_miso)
    );

    always #5 clk3p2M = ~clk3p2M;

    // ADC model: presents bit 15 while CS is high, shifts on SCLK falling,
    // captures MOSI on SCLK rising and flags MOSI moving on a rising edge.
    logic [15:0] respWord  = 16'd0;
    logic [15:0] cmdCap    = 16'd0;
    int          sclkRises = 0;
    int          mosiBad   = 0;
    int          bitIdx    = 0;
    logic        prevSclk  = 1'b0;
    logic        prevMosi  = 1'b0;

    always @(negedge clk3p2M) begin
        if (adc_cs_n) begin
            bitIdx   = 0;
            adc_miso = respWord[15];
        end else if (adc_sclk && !prevSclk) begin
            cmdCap = {cmdCap[14:0], adc_mosi};
            sclkRises++;
            if (adc_mosi !== prevMosi) mosiBad++;
        end else if (!adc_sclk && prevSclk) begin
            bitIdx++;
            adc_miso = (bitIdx < 16) ? respWord[15 - bitIdx] : 1'b0;
        end
        prevSclk = adc_sclk;
        prevMosi = adc_mosi;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, actual, expected);
        end
    endtask

    int   validCount;
    int   validCycle;
    int   inCycle;
    int   csFalls;
    logic busyAt0;
    logic csAt0;

    // Pulses go with chan, then observes 41 cycles; extra go pulses land on edges goA/goB.
    task automatic applyStimulus(input logic [3:0] chan, input logic [9:0] res,
                                 input int goA, input int goB, input logic [3:0] otherChan);
        logic [9:0] prevIn;
        logic       prevCs;
        respWord   = {6'd0, res};
        cmdCap     = 16'd0;
        sclkRises  = 0;
        validCount = 0;
        validCycle = -1;
        inCycle    = -1;
        csFalls    = 0;
        prevIn     = adc_in;
        prevCs     = 1'b1;
        adc_chan   = chan;
        adc_go     = 1'b1;
        @(posedge clk3p2M);
        #1;
        adc_go   = 1'b0;
        adc_chan = otherChan;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk3p2M);
                #1;
            end
            if (k == 0) begin
                busyAt0 = adc_busy;
                csAt0   = adc_cs_n;
            end
            if (adc_valid) begin
                validCount++;
                validCycle = k;
            end
            if (adc_in !== prevIn && inCycle < 0) inCycle = k;
            if (!adc_cs_n && prevCs) csFalls++;
            prevCs = adc_cs_n;
            adc_go = (k + 1 == goA) || (k + 1 == goB);
        end
        adc_go = 1'b0;
    endtask

    initial begin
        int   falls[0:7];
        int   fallCount;
        int   highRun;
        int   minHigh;
        int   qValid;
        logic [3:0] ch;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk3p2M);
        #1;
        checkOutput("reset cs_n",  32'(adc_cs_n),  32'd1);
        checkOutput("reset sclk",  32'(adc_sclk),  32'd0);
        checkOutput("reset mosi",  32'(adc_mosi),  32'd0);
        checkOutput("reset valid", 32'(adc_valid), 32'd0);
        checkOutput("reset busy",  32'(adc_busy),  32'd0);
        checkOutput("reset adcIn", 32'(adc_in),    32'd0);
        rst_n = 1'b1;
        @(posedge clk3p2M);
        #1;

        $display("[TB] single conversion, channel 5");
        applyStimulus(4'd5, 10'h2A5, -1, -1, 4'd12);
        checkOutput("single cmd",        32'(cmdCap),   32'hD400);
        checkOutput("single adcIn",      32'(adc_in),   32'h2A5);
        checkOutput("single validCount", validCount,    32'd1);
        checkOutput("single validCycle", validCycle,    32'd35);
        checkOutput("single inCycle",    inCycle,       32'd34);
        checkOutput("single sclkRises",  sclkRises,     32'd16);
        checkOutput("single busyAt0",    32'(busyAt0),  32'd1);
        checkOutput("single csAt0",      32'(csAt0),    32'd0);
        checkOutput("single busyEnd",    32'(adc_busy), 32'd0);
        checkOutput("single mosiStable", mosiBad,       32'd0);

        $display("[TB] channel sweep");
        for (int c = 0; c < 16; c++) begin
            ch = c[3:0];
            applyStimulus(ch, {ch, 6'h3F}, -1, -1, ~ch);
            checkOutput("sweep adcIn",      32'(adc_in), 32'({ch, 6'h3F}));
            checkOutput("sweep cmd",        32'(cmdCap), 32'({2'b11, ch, 10'd0}));
            checkOutput("sweep validCycle", validCycle,  32'd35);
        end
        checkOutput("sweep ch15 cmd", 32'(cmdCap), 32'hFC00);

        $display("[TB] requests while busy");
        applyStimulus(4'd3, 10'h155, 10, 36, 4'd9);
        checkOutput("busy cmd",        32'(cmdCap), 32'hCC00);
        checkOutput("busy validCount", validCount,  32'd1);
        checkOutput("busy csFalls",    csFalls,     32'd1);
        checkOutput("busy sclkRises",  sclkRises,   32'd16);
        checkOutput("busy adcIn",      32'(adc_in), 32'h155);
        repeat (5) @(posedge clk3p2M);
        #1;
        checkOutput("busy adcIn later", 32'(adc_in),   32'h155);
        checkOutput("busy cs later",    32'(adc_cs_n), 32'd1);

        $display("[TB] reset mid-frame");
        respWord = {6'd0, 10'h3C3};
        adc_chan = 4'd7;
        adc_go   = 1'b1;
        @(posedge clk3p2M);
        #1;
        adc_go = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk3p2M);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset cs_n",  32'(adc_cs_n), 32'd1);
        checkOutput("midreset sclk",  32'(adc_sclk), 32'd0);
        checkOutput("midreset mosi",  32'(adc_mosi), 32'd0);
        checkOutput("midreset adcIn", 32'(adc_in),   32'd0);
        checkOutput("midreset busy",  32'(adc_busy), 32'd0);
        qValid = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk3p2M);
            #1;
            if (adc_valid) qValid++;
            if (k == 4) rst_n = 1'b1;
        end
        checkOutput("midreset noValid", qValid, 32'd0);
        applyStimulus(4'd7, 10'h3C3, -1, -1, 4'd0);
        checkOutput("postreset adcIn",      32'(adc_in), 32'h3C3);
        checkOutput("postreset validCycle", validCycle,  32'd35);
        checkOutput("postreset cmd",        32'(cmdCap), 32'hDC00);

        $display("[TB] go held high");
        respWord  = {6'd0, 10'h0F0};
        mosiBad   = 0;
        adc_chan  = 4'd2;
        adc_go    = 1'b1;
        fallCount = 0;
        highRun   = 0;
        minHigh   = 999;
        qValid    = 0;
        for (int k = 0; k < 130; k++) begin
            @(posedge clk3p2M);
            #1;
            if (adc_valid) qValid++;
            if (adc_cs_n) begin
                highRun++;
            end else begin
                if (highRun > 0) begin
                    if (fallCount < 8) falls[fallCount] = k;
                    fallCount++;
                    if (highRun < minHigh) minHigh = highRun;
                end else if (k == 0) begin
                    falls[0]  = 0;
                    fallCount = 1;
                end
                highRun = 0;
            end
        end
        adc_go = 1'b0;
        checkOutput("quiet frames",  fallCount,            32'd4);
        checkOutput("quiet period1", falls[1] - falls[0],  32'd38);
        checkOutput("quiet period2", falls[2] - falls[1],  32'd38);
        checkOutput("quiet period3", falls[3] - falls[2],  32'd38);
        checkOutput("quiet minHigh", minHigh,              32'd3);
        checkOutput("quiet valids",  qValid,               32'd3);
        checkOutput("quiet mosi",    mosiBad,              32'd0);
        repeat (45) @(posedge clk3p2M);
        #1;
        checkOutput("quiet adcIn", 32'(adc_in),   32'h0F0);
        checkOutput("quiet idle",  32'(adc_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
